// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA 640x480@60 raster timing (coordinates, blank, delayed HS/VS, line/frame strobes)
// Ports: vga_clk/reset (async, active-high) in; DrawX/DrawY = hc/vc; blank = visible pixel;
//        hs/vs active-low syncs delayed SYNC_DELAY cycles; line_start/frame_start strobes;
//        frame_count (frames completed) only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // 11-bit bounds so a sync region ending exactly at 1024 still compares correctly
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_param_err
    $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY in 0..3");
  end
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       h_end, v_end, hs_raw, vs_raw;
  logic [10:0] hc_w, vc_w;
  always_comb begin
    h_end = hc_q == 10'(H_TOTAL - 1);
    v_end = vc_q == 10'(V_TOTAL - 1);
    hc_d  = h_end ? '0 : hc_q + 10'd1;
    vc_d  = h_end ? (v_end ? '0 : vc_q + 10'd1) : vc_q;
    hc_w  = {1'b0, hc_q};
    vc_w  = {1'b0, vc_q};
    hs_raw = !(hc_w >= HS_BEG && hc_w < HS_END);
    vs_raw = !(vc_w >= VS_BEG && vc_w < VS_END);
  end
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  // strobes are gated by reset so nothing downstream sees a pixel while held in reset
  assign blank       = !reset && hc_w < H_VIS && vc_w < V_VIS;
  assign line_start  = !reset && hc_q == '0;
  assign frame_start = !reset && hc_q == '0 && vc_q == '0;
  if (SYNC_DELAY == 0) begin : g_nodly
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0] hs_q, vs_q;
    // pipeline resets to idle-high so no partial pulse appears after release
    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        hs_q <= '1;
        vs_q <= '1;
      end else begin
        hs_q[0] <= hs_raw;
        vs_q[0] <= vs_raw;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hs_q[i] <= hs_q[i-1];
          vs_q[i] <= vs_q[i-1];
        end
      end
    end
    assign hs = hs_q[SYNC_DELAY-1];
    assign vs = vs_q[SYNC_DELAY-1];
  end
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;
  assign fc_d = (h_end && v_end) ? fc_q + 16'd1 : fc_q;
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) fc_q <= '0;
    else fc_q <= fc_d;
  end
  assign frame_count = fc_q;
`endif
endmodule
